// File: rtl/spi_tx_master_if.sv
// Word handshake from the host plus the SPI pins and status flags of spi_tx_master.
// The block itself connects through the slave modport.
interface spi_tx_master_if #(
    parameter int DATA_W = 16
) ();
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              busy;
    logic              done;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  sclk,
        input  cs_n,
        input  mosi,
        input  busy,
        input  done
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output sclk,
        output cs_n,
        output mosi,
        output busy,
        output done
    );
endinterface

// File: rtl/spi_tx_master.sv
// SPI transmit master: serialises one accepted word per CS_N frame in any CPOL/CPHA mode,
// with programmable SCLK divider, bit order and CS setup/hold.
module spi_tx_master #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_tx_master_if.slave tx_if
);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("spi_tx_master: DATA_W must be >= 2");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_tx_master: CLK_DIV must be >= 1");
    end
    if (CS_SETUP < 1) begin : g_bad_cs_setup
        $error("spi_tx_master: CS_SETUP must be >= 1");
    end
    if (CS_HOLD < 1) begin : g_bad_cs_hold
        $error("spi_tx_master: CS_HOLD must be >= 1");
    end

    // One counter serves the setup, divider and hold phases, so it is sized for the longest.
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int EDGE_W  = $clog2(2 * DATA_W + 1);

    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) begin
            return w[DATA_W-1];
        end else begin
            return w[0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) begin
            return {w[DATA_W-2:0], 1'b0};
        end else begin
            return {1'b0, w[DATA_W-1:1]};
        end
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [EDGE_W-1:0]   edge_next_s;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tx_ready_s;

    assign tx_ready_s     = (state_q == ST_IDLE) & ~rst;
    assign tx_if.tx_ready = tx_ready_s;
    assign tx_if.sclk     = sclk_q;
    assign tx_if.cs_n     = cs_n_q;
    assign tx_if.mosi     = mosi_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.done     = done_q;
    assign edge_next_s    = edge_q + EDGE_W'(1);

    // Next-state and next-output logic of the transfer sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d = CPOL;
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (tx_if.tx_valid && tx_ready_s) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_W'(0);
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    // CPHA=0 needs the first bit on the wire before the first leading edge.
                    if (CPHA) begin
                        shreg_d = tx_if.tx_data;
                        mosi_d  = 1'b0;
                    end else begin
                        shreg_d = shift_out(tx_if.tx_data);
                        mosi_d  = first_bit(tx_if.tx_data);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(0);
                    edge_d  = EDGE_W'(0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = CNT_W'(0);
                    sclk_d = ~sclk_q;
                    edge_d = edge_next_s;
                    // Even edges shift for CPHA=0, odd edges for CPHA=1; the last edge never shifts.
                    if (edge_next_s == LAST_EDGE) begin
                        state_d = ST_HOLD;
                    end else if (edge_next_s[0] == CPHA) begin
                        mosi_d  = first_bit(shreg_q);
                        shreg_d = shift_out(shreg_q);
                    end else begin
                        mosi_d = mosi_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = CPOL;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_W'(0);
            edge_q  <= EDGE_W'(0);
            shreg_q <= {DATA_W{1'b0}};
            sclk_q  <= CPOL;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
